fetch_queue: RTL and testbench

Parametrised instruction-fetch unit with a decoupling queue. It owns the program counter, issues sequential requests to a one-cycle-latency instruction memory, and buffers returned instructions with their PCs. It presents them to decode through a valid/ready handshake. Branch/jump redirects from the execute stage flush all buffered and in-flight fetches. It replaces the single-shot fetch stage and sits between the PC source and the IF/ID boundary.

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch unit: owns the PC, issues sequential requests to a one-cycle
// instruction memory and buffers returned instructions with their PCs for decode.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_base,
  input  logic [XLEN-1:0]         redirect_offset,
  output logic                    imem_req_valid,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic [ILEN-1:0]         imem_resp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ILEN-1:0]         out_instr,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_pc_plus4,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];

  logic            head_valid_s;
  logic            pop_s;
  logic            push_s;
  logic            issue_s;
  logic [CW:0]     credit_s;
  logic [XLEN-1:0] target_sum_s;
  logic [XLEN-1:0] target_s;

  // Handshake, credit and redirect-target decode.
  always_comb begin
    head_valid_s = (count_r != {CW{1'b0}}) && !rst;
    pop_s        = head_valid_s && out_ready;
    push_s       = inflight_r && !redirect_valid && !rst;
    // Queued plus in-flight entries, less the one leaving this cycle, must fit.
    credit_s     = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    issue_s      = !rst && !redirect_valid && (credit_s < DEPTH_C);
    target_sum_s = redirect_base + redirect_offset;
    target_s     = {target_sum_s[XLEN-1:2], 2'b00};
  end

  // Head presentation to decode; everything reads zero while empty or in reset.
  always_comb begin
    imem_req_valid = issue_s;
    imem_req_addr  = fetch_pc_r;
    out_valid      = head_valid_s;
    if (head_valid_s) begin
      out_instr    = instr_q[rd_ptr_r];
      out_pc       = pc_q[rd_ptr_r];
      out_pc_plus4 = pc_q[rd_ptr_r] + XLEN'(4);
    end else begin
      out_instr    = {ILEN{1'b0}};
      out_pc       = {XLEN{1'b0}};
      out_pc_plus4 = {XLEN{1'b0}};
    end
    if (rst) begin
      occupancy = {CW{1'b0}};
    end else begin
      occupancy = count_r;
    end
  end

  // PC, in-flight tracking and queue pointers; reset and redirect flush everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {XLEN{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r    <= target_s;
      inflight_r    <= 1'b0;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + XLEN'(4);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; no reset needed since entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_q[wr_ptr_r] <= imem_resp_data;
      pc_q[wr_ptr_r]    <= inflight_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a DEPTH=4 instance for most scenarios and a
// DEPTH=2 instance for the pointer-wrap run; imem returns addr ^ 0xA5A5_0000.
module tb_fetch_queue;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_base = 32'h0;
  logic [31:0] redirect_offset = 32'h0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] resp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  occupancy;

  logic        redirect_valid2 = 1'b0;
  logic [31:0] zero_word = 32'h0;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic [31:0] resp_data2 = 32'h0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic [31:0] out_pc_plus4_2;
  logic [1:0]  occupancy2;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // One-cycle-latency instruction memory models.
  always @(posedge clk) begin
    resp_data  <= req_addr ^ TAG;
    resp_data2 <= req_addr2 ^ TAG;
  end

  fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_base(redirect_base),
    .redirect_offset(redirect_offset),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .occupancy(occupancy)
  );

  fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(2), .RESET_PC(32'h0)) dut2 (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid2), .redirect_base(zero_word),
    .redirect_offset(zero_word),
    .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
    .imem_resp_data(resp_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_pc(out_pc2), .out_pc_plus4(out_pc_plus4_2), .occupancy(occupancy2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of C0 (first cycle with rst low).
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int pops2;
    logic [31:0] exp_pc2;

    // Reset state and startup with out_ready=1.
    out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    #1;
    check_eq("rst_req_valid", 32'(req_valid), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_pc_plus4", out_pc_plus4, 32'h0);
    check_eq("rst_occupancy", 32'(occupancy), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check_eq("c0_req_valid", 32'(req_valid), 32'h1);
    check_eq("c0_req_addr", req_addr, 32'h0);
    check_eq("c0_out_valid", 32'(out_valid), 32'h0);
    cyc();
    #1;
    check_eq("c1_req_addr", req_addr, 32'h4);
    check_eq("c1_out_valid", 32'(out_valid), 32'h0);
    cyc();
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("stream_valid", 32'(out_valid), 32'h1);
      check_eq("stream_pc", out_pc, 32'(4 * k));
      check_eq("stream_instr", out_instr, 32'(4 * k) ^ TAG);
      check_eq("stream_plus4", out_pc_plus4, 32'(4 * k + 4));
      check_eq("stream_req_addr", req_addr, 32'(8 + 4 * k));
      cyc();
    end

    // Back-pressure: exactly four requests, then resume with no gap.
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("bp_req_valid", 32'(req_valid), 32'h1);
      check_eq("bp_req_addr", req_addr, 32'(4 * k));
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bp_stall", 32'(req_valid), 32'h0);
      if (k == 2) begin
        check_eq("bp_occupancy", 32'(occupancy), 32'h4);
      end
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("bp_drain_pc", out_pc, 32'(4 * k));
      check_eq("bp_resume_valid", 32'(req_valid), 32'h1);
      check_eq("bp_resume_addr", req_addr, 32'(16 + 4 * k));
      cyc();
    end

    // Redirect at cycle 5 to 0x100 + (-8).
    out_ready = 1'b1;
    do_reset();
    repeat (5) cyc();
    redirect_valid  = 1'b1;
    redirect_base   = 32'h0000_0100;
    redirect_offset = 32'hFFFF_FFF8;
    #1;
    check_eq("rd_no_issue", 32'(req_valid), 32'h0);
    check_eq("rd_head_pc", out_pc, 32'hC);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("rd_target_req", req_addr, 32'hF8);
    check_eq("rd_target_valid", 32'(req_valid), 32'h1);
    check_eq("rd_flush_valid6", 32'(out_valid), 32'h0);
    check_eq("rd_flush_occ", 32'(occupancy), 32'h0);
    cyc();
    #1;
    check_eq("rd_flush_valid7", 32'(out_valid), 32'h0);
    check_eq("rd_next_req", req_addr, 32'hFC);
    cyc();
    #1;
    check_eq("rd_first_pc", out_pc, 32'hF8);
    check_eq("rd_first_instr", out_instr, 32'hF8 ^ TAG);
    cyc();
    #1;
    check_eq("rd_second_pc", out_pc, 32'hFC);

    // Redirect coinciding with push and pop; target 0x203 aligns to 0x200.
    do_reset();
    repeat (4) cyc();
    redirect_valid  = 1'b1;
    redirect_base   = 32'h0000_0200;
    redirect_offset = 32'h0000_0003;
    #1;
    check_eq("rpp_head_valid", 32'(out_valid), 32'h1);
    check_eq("rpp_head_pc", out_pc, 32'h8);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("rpp_occupancy", 32'(occupancy), 32'h0);
    check_eq("rpp_req_addr", req_addr, 32'h200);
    check_eq("rpp_out_valid", 32'(out_valid), 32'h0);
    cyc();
    cyc();
    #1;
    check_eq("rpp_first_pc", out_pc, 32'h200);

    // DEPTH=2 with alternating out_ready: wrap, contiguity, bounded occupancy.
    do_reset();
    pops2 = 0;
    exp_pc2 = 32'h0;
    for (int i = 0; i < 40; i++) begin
      out_ready2 = (i % 2 == 0);
      #1;
      check_eq("d2_occ_bound", 32'(occupancy2 <= 2'd2), 32'h1);
      if (out_valid2 && out_ready2) begin
        check_eq("d2_pc", out_pc2, exp_pc2);
        check_eq("d2_instr", out_instr2, exp_pc2 ^ TAG);
        exp_pc2 = exp_pc2 + 32'h4;
        pops2++;
      end
      cyc();
    end
    check_eq("d2_pop_count", 32'(pops2), 32'd19);
    out_ready2 = 1'b1;

    // PC wrap at the top of the address space, then reset with a full queue.
    out_ready = 1'b0;
    do_reset();
    redirect_valid  = 1'b1;
    redirect_base   = 32'hFFFF_FFFC;
    redirect_offset = 32'h0;
    #1;
    check_eq("wrap_no_issue", 32'(req_valid), 32'h0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("wrap_req_top", req_addr, 32'hFFFF_FFFC);
    cyc();
    #1;
    check_eq("wrap_req_zero", req_addr, 32'h0);
    check_eq("wrap_req_valid", 32'(req_valid), 32'h1);
    repeat (4) cyc();
    #1;
    check_eq("full_occupancy", 32'(occupancy), 32'h4);
    check_eq("full_head_pc", out_pc, 32'hFFFF_FFFC);
    check_eq("full_plus4_wrap", out_pc_plus4, 32'h0);
    cyc();
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'h0);
    check_eq("midrst_pc", out_pc, 32'h0);
    check_eq("midrst_instr", out_instr, 32'h0);
    check_eq("midrst_req", 32'(req_valid), 32'h0);
    check_eq("midrst_occ", 32'(occupancy), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check_eq("postrst_req_valid", 32'(req_valid), 32'h1);
    check_eq("postrst_req_addr", req_addr, 32'h0);
    check_eq("postrst_occ", 32'(occupancy), 32'h0);
    cyc();
    #1;
    check_eq("postrst_out_valid", 32'(out_valid), 32'h0);
    check_eq("postrst_req_addr2", req_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
